// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin mux arbiter:
// FSM state encodings, the default burst length and a small grant helper.
package mux2_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam int DEFAULT_MAX_BURST = 4;

    // Ownership state for requester k.
    function automatic arb_state_t own_state(input logic k);
        return k ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/mux2_rr_arbiter_mux2to1.sv
// Single-bit 2:1 multiplexer used as the data-path cell of the arbiter.
// y = a when sel is 0, b when sel is 1.
module mux2to1 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter owning a shared 2:1 data mux in front of one valid/ready consumer.
// A grant lasts until its requester drops req or MAX_BURST beats are accepted.
module mux2_rr_arbiter
    import mux2_rr_arbiter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 req0,
    input  logic [WIDTH-1:0]                     data0,
    input  logic                                 req1,
    input  logic [WIDTH-1:0]                     data1,
    output logic                                 gnt0,
    output logic                                 gnt1,
    output logic                                 sel,
    output logic                                 out_valid,
    output logic [WIDTH-1:0]                     out_data,
    input  logic                                 out_ready,
    output logic [1:0]                           dbg_state,
    output logic                                 dbg_rr,
    output logic [$clog2(MAX_BURST+1)-1:0]       dbg_beat_cnt
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

    // Handshake: a beat transfers on a rising clk edge where out_valid and
    // out_ready are both high; out_valid never waits on out_ready, and the
    // owning requester keeps its data stable while req && gnt && !out_ready.

    arb_state_t       state, state_nxt;
    logic             sel_q, sel_nxt;
    logic             rr_q, rr_nxt;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;

    logic owner;
    logic own_req;
    logic other_req;
    logic accept;
    logic burst_done;
    logic grant_k;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel_q    <= 1'b0;
            rr_q     <= 1'b0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            sel_q    <= sel_nxt;
            rr_q     <= rr_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        sel_nxt      = sel_q;
        rr_nxt       = rr_q;
        beat_cnt_nxt = beat_cnt;
        grant_k      = 1'b0;

        owner      = (state == OWN1);
        own_req    = owner ? req1 : req0;
        other_req  = owner ? req0 : req1;
        out_valid  = (state != IDLE) && own_req;
        accept     = out_valid && out_ready;
        burst_done = accept && (beat_cnt == LAST_CNT);

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant_k      = (req0 && req1) ? rr_q : req1;
                    state_nxt    = own_state(grant_k);
                    sel_nxt      = grant_k;
                    rr_nxt       = !grant_k;
                    beat_cnt_nxt = '0;
                end
            end
            OWN0, OWN1: begin
                if (!own_req || burst_done) begin
                    // Release and re-arbitrate on the same edge so handover has no bubble.
                    if (other_req) begin
                        grant_k      = !owner;
                        state_nxt    = own_state(grant_k);
                        sel_nxt      = grant_k;
                        rr_nxt       = owner;
                        beat_cnt_nxt = '0;
                    end else if (own_req) begin
                        grant_k      = owner;
                        state_nxt    = own_state(grant_k);
                        sel_nxt      = grant_k;
                        rr_nxt       = !owner;
                        beat_cnt_nxt = '0;
                    end else begin
                        state_nxt    = IDLE;
                        beat_cnt_nxt = '0;
                    end
                end else if (accept) begin
                    beat_cnt_nxt = beat_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt    = IDLE;
                beat_cnt_nxt = '0;
            end
        endcase
    end

    assign gnt0         = (state == OWN0);
    assign gnt1         = (state == OWN1);
    assign sel          = sel_q;
    assign dbg_state    = state;
    assign dbg_rr       = rr_q;
    assign dbg_beat_cnt = beat_cnt;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            mux2to1 u_mux (
                .a  (data0[i]),
                .b  (data1[i]),
                .sel(sel_q),
                .y  (out_data[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: two instances (MAX_BURST 4 and 2) share all inputs
// and are compared every cycle against an owner/beat-count reference model.
module tb_mux2_rr_arbiter;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         req0 = 1'b0;
    logic         req1 = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] data0 = '0;
    logic [W-1:0] data1 = '0;

    // index 0: MAX_BURST=4 instance, index 1: MAX_BURST=2 instance
    logic [1:0]   gnt0_w, gnt1_w, sel_w, valid_w, rr_w;
    logic [W-1:0] od4, od2;
    logic [1:0]   st4, st2;
    logic [2:0]   cnt4;
    logic [1:0]   cnt2;

    mux2_rr_arbiter #(.WIDTH(W), .MAX_BURST(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .gnt0(gnt0_w[0]), .gnt1(gnt1_w[0]), .sel(sel_w[0]),
        .out_valid(valid_w[0]), .out_data(od4), .out_ready(out_ready),
        .dbg_state(st4), .dbg_rr(rr_w[0]), .dbg_beat_cnt(cnt4)
    );

    mux2_rr_arbiter #(.WIDTH(W), .MAX_BURST(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .gnt0(gnt0_w[1]), .gnt1(gnt1_w[1]), .sel(sel_w[1]),
        .out_valid(valid_w[1]), .out_data(od2), .out_ready(out_ready),
        .dbg_state(st2), .dbg_rr(rr_w[1]), .dbg_beat_cnt(cnt2)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // owner: -1 none, else requester index; beats: accepted beats in current grant
    int m_own[2];
    int m_cnt[2];
    int m_rr[2];
    int m_sel[2];
    int m_burst[2] = '{4, 2};

    function automatic int req_of(input int j);
        return (j == 0) ? int'(req0) : int'(req1);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_own[k] = -1; m_cnt[k] = 0; m_rr[k] = 0; m_sel[k] = 0;
        end
    endtask

    task automatic model_grant(input int k, input int j);
        m_own[k] = j; m_sel[k] = j; m_rr[k] = 1 - j; m_cnt[k] = 0;
    endtask

    task automatic model_edge();
        int o;
        bit acc;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            if (m_own[k] < 0) begin
                if (req0 && req1)  model_grant(k, m_rr[k]);
                else if (req0)     model_grant(k, 0);
                else if (req1)     model_grant(k, 1);
            end else begin
                o   = m_own[k];
                acc = (req_of(o) != 0) && out_ready;
                if (acc) begin
                    m_cnt[k]++;
                    if (k == 0) exp_q.push_back(o ? data1 : data0);
                end
                if (req_of(o) == 0 || (acc && m_cnt[k] == m_burst[k])) begin
                    if (req_of(1 - o) != 0)  model_grant(k, 1 - o);
                    else if (req_of(o) != 0) model_grant(k, o);
                    else begin m_own[k] = -1; m_cnt[k] = 0; end
                end
            end
        end
    endtask

    task automatic check_outputs();
        int ev;
        for (int k = 0; k < 2; k++) begin
            ev = (m_own[k] >= 0 && req_of(m_own[k] < 0 ? 0 : m_own[k]) != 0) ? 1 : 0;
            chk($sformatf("gnt0[%0d]", k), gnt0_w[k], m_own[k] == 0);
            chk($sformatf("gnt1[%0d]", k), gnt1_w[k], m_own[k] == 1);
            chk($sformatf("sel[%0d]", k), sel_w[k], m_sel[k]);
            chk($sformatf("out_valid[%0d]", k), valid_w[k], ev);
            chk($sformatf("out_data[%0d]", k), (k == 0) ? od4 : od2, m_sel[k] ? data1 : data0);
            chk($sformatf("beat_cnt[%0d]", k), (k == 0) ? int'(cnt4) : int'(cnt2), m_cnt[k]);
            chk($sformatf("rr[%0d]", k), rr_w[k], m_rr[k]);
            chk($sformatf("state[%0d]", k), (k == 0) ? st4 : st2, m_own[k] < 0 ? 0 : m_own[k] + 1);
        end
        if (valid_w[0] && out_ready) got_q.push_back(od4);
    endtask

    // ---------------- driver tasks ----------------
    // One cycle: compare at negedge, advance model at posedge, return 1 time unit later.
    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        while (exp_q.size() > 0 && got_q.size() > 0)
            chk("beat_data", got_q.pop_front(), exp_q.pop_front());
        #1;
    endtask

    task automatic do_reset();
        req0 = 1'b0; req1 = 1'b0; out_ready = 1'b0;
        rst_n = 1'b0;
        model_reset();
        step();
        step();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic r0, r1, rdy;
        logic eg0, eg1, esel, evalid;
        int   ecnt;
    } vec_t;

    vec_t tbl[9];

    initial begin
        // tie from reset on the MAX_BURST=2 instance; expectations are post-edge
        tbl[0] = '{1, 1, 1, 1, 0, 0, 1, 0};
        tbl[1] = '{1, 1, 1, 1, 0, 0, 1, 1};
        tbl[2] = '{1, 1, 1, 0, 1, 1, 1, 0};
        tbl[3] = '{1, 1, 1, 0, 1, 1, 1, 1};
        tbl[4] = '{1, 1, 1, 1, 0, 0, 1, 0};
        tbl[5] = '{1, 1, 1, 1, 0, 0, 1, 1};
        tbl[6] = '{1, 1, 1, 0, 1, 1, 1, 0};
        tbl[7] = '{0, 0, 1, 0, 0, 1, 0, 0};
        tbl[8] = '{0, 1, 1, 0, 1, 1, 1, 0};

        model_reset();
        do_reset();
        data0 = 8'h11; data1 = 8'h22;
        for (int i = 0; i < 9; i++) begin
            req0 = tbl[i].r0; req1 = tbl[i].r1; out_ready = tbl[i].rdy;
            step();
            chk($sformatf("tbl%0d_gnt0", i), gnt0_w[1], tbl[i].eg0);
            chk($sformatf("tbl%0d_gnt1", i), gnt1_w[1], tbl[i].eg1);
            chk($sformatf("tbl%0d_sel", i), sel_w[1], tbl[i].esel);
            chk($sformatf("tbl%0d_valid", i), valid_w[1], tbl[i].evalid);
            chk($sformatf("tbl%0d_cnt", i), cnt2, tbl[i].ecnt);
        end

        // single requester, continuous beats, burst counter wraps every 4
        do_reset();
        req0 = 1'b1; data0 = 8'hA5; out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk("single_gnt0", gnt0_w[0], 1);
            chk("single_cnt", cnt4, (i - 1) % 4);
            chk("single_data", od4, 8'hA5);
        end

        // early release after one beat, then backpressure on requester 1
        do_reset();
        req0 = 1'b1; req1 = 1'b0; data0 = 8'h5A; out_ready = 1'b1;
        step();
        step();
        req0 = 1'b0; req1 = 1'b1; data1 = 8'h3C;
        step();
        chk("early_gnt1", gnt1_w[0], 1);
        chk("early_gnt0", gnt0_w[0], 0);
        chk("early_sel", sel_w[0], 1);
        chk("early_cnt", cnt4, 0);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_gnt1", gnt1_w[0], 1);
            chk("bp_valid", valid_w[0], 1);
            chk("bp_data", od4, 8'h3C);
            chk("bp_cnt", cnt4, 0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_resume_cnt", cnt4, 1);

        // asynchronous reset in the middle of the burst
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_valid", valid_w, 0);
        chk("arst_gnt1", gnt1_w, 0);
        chk("arst_sel", sel_w, 0);
        chk("arst_cnt", cnt4, 0);
        chk("arst_data", od4, data0);
        req0 = 1'b0; req1 = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("idle_gnt", {gnt0_w, gnt1_w}, 0);
        chk("idle_valid", valid_w, 0);
        chk("idle_rr", rr_w, 0);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            bit hold0, hold1;
            hold0 = 0; hold1 = 0;
            for (int k = 0; k < 2; k++) begin
                if (m_own[k] == 0 && req0 && !out_ready) hold0 = 1;
                if (m_own[k] == 1 && req1 && !out_ready) hold1 = 1;
            end
            if (!hold0) data0 = W'($urandom_range(0, 255));
            if (!hold1) data1 = W'($urandom_range(0, 255));
            req0      = ($urandom_range(0, 3) != 0);
            req1      = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
        chk("beat_queue_left", got_q.size(), exp_q.size());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
